// File: rtl/round_hu.sv
// Registered round-half-up for signed fixed-point data: adds one half-LSB of the
// integer part, clears the fractional bits, and clamps positive overflow.
module round_hu #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [WIDTH-1:0] round_a,
  output logic             sat
);

  localparam logic [WIDTH:0]   HALF     = {{WIDTH{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic [WIDTH-1:0] INT_MASK = {WIDTH{1'b1}} << FRAC;
  localparam logic [WIDTH-1:0] MAX_INT  = INT_MASK & {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH:0]   sum;
  logic             overflow;
  logic [WIDTH-1:0] rounded;

  always_comb begin
    sum = {a[WIDTH-1], a} + HALF;
    // Adding a positive constant can only overflow upward, which shows up as the
    // extended sign disagreeing with the WIDTH-bit sign.
    overflow = sum[WIDTH] ^ sum[WIDTH-1];
    rounded  = overflow ? MAX_INT : (sum[WIDTH-1:0] & INT_MASK);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      round_a   <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        round_a <= rounded;
        sat     <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_round_hu.sv
// Self-checking bench for round_hu: directed test-plan steps followed by random
// traffic, compared against a floor(x + 0.5) integer reference model.
module tb_round_hu;

  localparam int WIDTH = 16;
  localparam int FRAC  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic [WIDTH-1:0] round_a;
  logic             sat;

  int compared   = 0;
  int mismatched = 0;

  // Expected output state kept by the reference model.
  logic             exp_valid;
  logic [WIDTH-1:0] exp_round;
  logic             exp_sat;

  round_hu #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .out_valid(out_valid),
    .round_a  (round_a),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // floor(x + 0.5) on the real value, scaled back; clamps past the largest integer.
  task automatic model(input logic [WIDTH-1:0] val, output logic [WIDTH-1:0] r, output logic s);
    int v;
    int rounded;
    int max_int;
    v       = int'($signed(val));
    rounded = ((v + (1 << (FRAC - 1))) >>> FRAC) << FRAC;
    max_int = ((1 << (WIDTH - 1)) - 1) & ~((1 << FRAC) - 1);
    if (rounded > max_int) begin
      r = max_int[WIDTH-1:0];
      s = 1'b1;
    end else begin
      r = rounded[WIDTH-1:0];
      s = 1'b0;
    end
  endtask

  // One clock: apply inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic rst_v, input logic v, input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] r;
    logic             s;
    rst_n    = rst_v;
    in_valid = v;
    a        = val;
    @(posedge clk);
    #1;
    if (!rst_v) begin
      exp_valid = 1'b0;
      exp_round = '0;
      exp_sat   = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        model(val, r, s);
        exp_round = r;
        exp_sat   = s;
      end
    end
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".round"}, 32'(round_a), 32'(exp_round));
    check({tag, ".sat"},   32'(sat), 32'(exp_sat));
  endtask

  logic [WIDTH-1:0] pos_in   [6] = '{16'h0005, 16'h0004, 16'h0007, 16'h000C, 16'h000E, 16'h000F};
  logic [WIDTH-1:0] pos_exp  [6] = '{16'h0008, 16'h0008, 16'h0008, 16'h0010, 16'h0010, 16'h0010};
  logic [WIDTH-1:0] neg_in   [5] = '{16'hFFFF, 16'hFFF8, 16'hFFF9, 16'hFFFC, 16'hFFFD};
  logic [WIDTH-1:0] neg_exp  [5] = '{16'h0000, 16'hFFF8, 16'hFFF8, 16'h0000, 16'h0000};
  logic [WIDTH-1:0] edge_vals[6] = '{16'h7FFC, 16'h7FFB, 16'h8000, 16'h7FFF, 16'h7FF8, 16'h8004};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    exp_valid = 1'b0;
    exp_round = '0;
    exp_sat   = 1'b0;

    // Reset dominates in_valid.
    step("reset0", 1'b0, 1'b1, 16'h0005);
    step("reset1", 1'b0, 1'b1, 16'h0005);
    check("reset.round_const", 32'(round_a), 32'h0);

    // Positive rounding, back-to-back; fixed expectations cross-check the model.
    foreach (pos_in[i]) begin
      step("pos", 1'b1, 1'b1, pos_in[i]);
      check("pos.table", 32'(round_a), 32'(pos_exp[i]));
    end

    // Negative values and ties toward +inf.
    foreach (neg_in[i]) begin
      step("neg", 1'b1, 1'b1, neg_in[i]);
      check("neg.table", 32'(round_a), 32'(neg_exp[i]));
    end

    // Saturation and extremes.
    step("sat_7ffc", 1'b1, 1'b1, 16'h7FFC);
    check("sat_7ffc.const", {15'd0, sat, round_a}, {15'd0, 1'b1, 16'h7FF8});
    step("nosat_7ffb", 1'b1, 1'b1, 16'h7FFB);
    check("nosat_7ffb.const", {15'd0, sat, round_a}, {15'd0, 1'b0, 16'h7FF8});
    step("min_8000", 1'b1, 1'b1, 16'h8000);
    check("min_8000.const", {15'd0, sat, round_a}, {15'd0, 1'b0, 16'h8000});
    // Saturate then idle: sat must hold.
    step("sat_hold0", 1'b1, 1'b1, 16'h7FFF);
    step("sat_hold1", 1'b1, 1'b0, 16'h0000);

    // Valid gating: outputs hold while out_valid drops.
    step("gate0", 1'b1, 1'b1, 16'h000C);
    step("gate1", 1'b1, 1'b0, 16'h1234);
    step("gate2", 1'b1, 1'b0, 16'h1234);
    check("gate.hold_const", 32'(round_a), 32'h0010);

    // Mid-stream reset.
    step("mid0", 1'b1, 1'b1, 16'h0123);
    step("mid_rst", 1'b0, 1'b1, 16'h0456);
    step("mid_post", 1'b1, 1'b1, 16'h0789);

    // Random traffic with occasional resets and boundary operands.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] val;
      logic             rv;
      logic             v;
      val = $urandom_range(0, 3) == 0 ? edge_vals[$urandom_range(0, 5)] : WIDTH'($urandom);
      rv  = ($urandom_range(0, 39) != 0);
      v   = ($urandom_range(0, 3) != 0);
      step("rand", rv, v, val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/round_hu.md
Name: round_hu

Overview:
- Registered round-half-up unit for signed two's-complement fixed-point data.
- Input is a WIDTH-bit value with FRAC fractional bits. Output is the same format, rounded to the nearest integer, with ties going toward +infinity; the fractional bits are forced to zero.
- Sits in the DNN MAC datapath after accumulation and before re-quantisation of results.

Parameters:
- WIDTH, 16, total bit width of input and output (signed two's complement).
- FRAC, 3, number of fractional bits; legal range 1 to WIDTH-2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  qualifies a for the current cycle.
- a  input  WIDTH  signed fixed-point operand.
- out_valid  output  1  round_a and sat hold a valid result.
- round_a  output  WIDTH  rounded result, same format as a, with low FRAC bits equal to 0.
- sat  output  1  high when the result was clamped because of positive overflow.

Behaviour:
- Reset: when rst_n=0 at a rising edge, out_valid, round_a and sat are all set to 0. Reset takes priority over in_valid.
- Latency and throughput:
  - Latency is 1 cycle; one operand is accepted per cycle.
  - There is no backpressure.
  - An operand sampled with in_valid=1 at edge N appears on round_a with out_valid=1 after edge N.
- Idle cycles: when in_valid=0, out_valid goes to 0 at the next edge. round_a and sat hold their previous values.
- Arithmetic:
  - Let H = 2^(FRAC-1), the value of one half-LSB of the integer part.
  - Compute s = a + H at WIDTH+1 bits, with a sign-extended.
  - round_a = s with the low FRAC bits cleared, truncated to WIDTH bits.
  - Equivalent to floor(x + 0.5) where x = a / 2^FRAC.
- Tie behaviour (fraction exactly 0.5):
  - Positive ties round up; for example 0.5 becomes 1.0.
  - Negative ties round toward zero; for example -0.5 becomes 0 and -1.5 becomes -1.0.
  - This applies to both signs; it is not round-half-away-from-zero.
- Integer-valued inputs (low FRAC bits all 0) pass through unchanged.
- Overflow:
  - The only possible overflow is a positive input close to the maximum (a > max - H) rounding past the largest representable integer.
  - In that case round_a = the largest positive value with low FRAC bits 0 (0x7FF8 for the defaults), and sat=1.
  - sat is 0 in all other cases.
  - Negative inputs can never overflow; the most negative input (0x8000) maps to itself.
- Reset mid-stream: any in-flight result is discarded. The first valid output after reset comes from the first in_valid=1 cycle with rst_n=1.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and a=0x0005 -> out_valid=0, round_a=0x0000, sat=0.
- Positive rounding, back-to-back: stream a=0x0005, 0x0004, 0x0007, 0x000C, 0x000E, 0x000F with in_valid=1 -> one cycle later round_a = 0x0008, 0x0008, 0x0008, 0x0010, 0x0010, 0x0010, with out_valid=1 throughout and sat=0.
- Negative values and ties: stream a=0xFFFF (-1), 0xFFF8 (-8), 0xFFF9 (-7), 0xFFFC (-4), 0xFFFD (-3) -> round_a = 0x0000, 0xFFF8, 0xFFF8, 0x0000, 0x0000.
- Saturation and extremes:
  - a=0x7FFC -> round_a=0x7FF8, sat=1.
  - a=0x7FFB -> round_a=0x7FF8, sat=0.
  - a=0x8000 -> round_a=0x8000, sat=0.
- Valid gating: send a=0x000C with in_valid=1, then 2 cycles with in_valid=0 and a=0x1234 -> round_a stays 0x0010 while out_valid goes 1, 0, 0.
- Mid-stream reset: assert rst_n=0 for one cycle in the middle of a stream -> outputs go to 0 on that edge, and the first result after reset matches the first post-reset operand.
